chan_sched8_n: RTL and testbench

CHAN_SCHED8_N -- requirements
Module: chan_sched8_n

---
 rtl/chan_sched8_n.sv | 121 ++++++++++++
 tb/tb_chan_sched8_n.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_sched8_n.sv
// Eight-slot holding buffer with a round-robin scheduler that presents one item
// at a time through a downstream 8:1 mux (sel_o selects a word of hold_data_o).
module chan_sched8_n #(
  parameter int n = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [7:0]     in_valid_i,
  input  logic [8*n-1:0] in_data_i,
  output logic [7:0]     in_ready_o,
  output logic [8*n-1:0] hold_data_o,
  output logic [2:0]     sel_o,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  input  logic           flush_i,
  output logic [3:0]     count_o,
  output logic           dbg_state_o,
  output logic [2:0]     dbg_ptr_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a valid item stays stable until it is accepted, and ready never
  // depends combinationally on valid.

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [7:0]     full_q, full_d;
  logic [8*n-1:0] data_q;
  logic [2:0]     sel_q, sel_d;
  logic [2:0]     ptr_q, ptr_d;
  logic [7:0]     load;
  logic [7:0]     drain;
  logic           found;
  logic [2:0]     pick;
  logic [2:0]     idx;
  logic [3:0]     cnt;

  // Ready comes only from registered flags; a flush also blocks loading.
  assign load = in_valid_i & ~full_q & {8{~flush_i}};

  // First full slot at or after ptr, circularly.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = '0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!found && full_q[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    drain   = '0;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            sel_d   = pick;
            state_d = PRESENT;
          end
        end
        PRESENT: begin
          if (out_ready_i) begin
            drain   = 8'(1) << sel_q;
            ptr_d   = sel_q + 3'd1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    full_d = flush_i ? 8'h00 : ((full_q | load) & ~drain);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      full_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (load[k]) data_q[k*n +: n] <= in_data_i[k*n +: n];
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, full_q[i]};
  end

  assign in_ready_o  = ~full_q;
  assign hold_data_o = data_q;
  assign sel_o       = sel_q;
  assign out_valid_o = (state_q == PRESENT);
  assign count_o     = cnt;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_chan_sched8_n.sv
// Bench for chan_sched8_n: table-driven load bursts drained through a
// scoreboard of expected {slot, data} items, plus hand-written corner cases.
module tb_chan_sched8_n;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     in_valid;
  logic [8*N-1:0] in_data;
  logic [7:0]     in_ready;
  logic [8*N-1:0] hold_data;
  logic [2:0]     sel;
  logic           out_valid;
  logic           out_ready;
  logic           flush;
  logic [3:0]     count;
  logic           dbg_state;
  logic [2:0]     dbg_ptr;

  chan_sched8_n #(.n(N)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .hold_data_o (hold_data),
    .sel_o       (sel),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .flush_i     (flush),
    .count_o     (count),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mask;
    logic [3:0] base;
  } vec_t;

  vec_t       tbl[6];
  logic [6:0] exp_q[$];
  logic [2:0] model_ptr;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample/drive point: 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] mux_out();
    return hold_data[sel*N +: N];
  endfunction

  task automatic drain(input int budget);
    int cyc;
    logic [6:0] item;
    cyc = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && cyc < budget) begin
      if (out_valid) begin
        item = exp_q.pop_front();
        check("serve_sel", 32'(sel), 32'(item[6:4]));
        check("serve_data", 32'(mux_out()), 32'(item[3:0]));
        model_ptr = item[6:4] + 3'd1;
      end
      step();
      cyc++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // Load all slots in mask in one cycle from an empty, idle scheduler.
  task automatic burst(input logic [7:0] mask, input logic [3:0] base);
    logic [2:0] s;
    out_ready = 1'b1;
    in_valid  = mask;
    for (int k = 0; k < 8; k++) in_data[k*N +: N] = 4'(base + 4'(k));
    step();
    in_valid = '0;
    check("burst_count", 32'(count), 32'($countones(mask)));
    check("burst_not_yet_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      s = 3'(model_ptr + 3'(i));
      if (mask[s]) exp_q.push_back({s, 4'(base + 4'(s))});
    end
    drain(40);
    check("burst_empty_count", 32'(count), 32'd0);
    check("burst_ptr", 32'(dbg_ptr), 32'(model_ptr));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    model_ptr = '0;
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(in_ready), 32'hFF);
    check("rst_hold", hold_data, 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single item into slot 5.
    out_ready = 1'b1;
    in_valid = 8'h20; in_data[5*N +: N] = 4'hA;
    step();
    in_valid = '0;
    check("single_count1", 32'(count), 32'd1);
    check("single_ready", 32'(in_ready), 32'hDF);
    check("single_valid_early", 32'(out_valid), 32'd0);
    step();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_sel", 32'(sel), 32'd5);
    check("single_data", 32'(mux_out()), 32'hA);
    step();
    check("single_count0", 32'(count), 32'd0);
    check("single_ptr", 32'(dbg_ptr), 32'd6);
    check("single_idle", 32'(out_valid), 32'd0);
    model_ptr = 3'd6;

    // Restart from ptr 0 for the round-robin table.
    rst_n = 1'b0; #2; rst_n = 1'b1;
    model_ptr = '0;
    tbl[0] = '{mask: 8'h89, base: 4'h1};
    tbl[1] = '{mask: 8'h01, base: 4'h6};
    tbl[2] = '{mask: 8'hFF, base: 4'h2};
    tbl[3] = '{mask: 8'h42, base: 4'h9};
    tbl[4] = '{mask: 8'($urandom_range(1, 255)), base: 4'($urandom_range(0, 15))};
    tbl[5] = '{mask: 8'($urandom_range(1, 255)), base: 4'($urandom_range(0, 15))};
    step();
    for (int t = 0; t < 6; t++) burst(tbl[t].mask, tbl[t].base);

    // Backpressure while the other seven slots fill up.
    out_ready = 1'b0;
    in_valid = 8'h01; in_data[0 +: N] = 4'h5;
    step();
    in_valid = '0;
    step();
    in_valid = 8'hFE;
    for (int k = 0; k < 8; k++) in_data[k*N +: N] = 4'(k + 8);
    in_data[0 +: N] = 4'hF;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sel", 32'(sel), 32'd0);
      check("bp_data", 32'(mux_out()), 32'h5);
      step();
    end
    in_valid = '0;
    check("bp_count", 32'(count), 32'd8);
    check("bp_ready", 32'(in_ready), 32'h00);
    exp_q.push_back({3'd0, 4'h5});
    for (int k = 1; k < 8; k++) exp_q.push_back({3'(k), 4'(k + 8)});
    drain(40);
    check("bp_ptr", 32'(dbg_ptr), 32'(model_ptr));

    // Overwrite attempt on a full slot.
    out_ready = 1'b0;
    in_valid = 8'h04; in_data[2*N +: N] = 4'h3;
    step();
    in_data[2*N +: N] = 4'hC;
    step(); step(); step();
    in_valid = '0;
    check("ovw_hold", 32'(hold_data[2*N +: N]), 32'h3);
    exp_q.push_back({3'd2, 4'h3});
    drain(20);

    // Flush beats a coincident transfer and load.
    out_ready = 1'b0;
    in_valid = 8'h0F;
    for (int k = 0; k < 4; k++) in_data[k*N +: N] = 4'(k + 1);
    step();
    in_valid = '0;
    step();
    check("fl_pre_sel", 32'(sel), 32'd3);
    check("fl_pre_count", 32'(count), 32'd4);
    flush = 1'b1; out_ready = 1'b1;
    in_valid = 8'h10; in_data[4*N +: N] = 4'hE;
    step();
    flush = 1'b0; in_valid = '0;
    check("fl_count", 32'(count), 32'd0);
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready), 32'hFF);
    check("fl_ptr", 32'(dbg_ptr), 32'(model_ptr));
    check("fl_sel", 32'(sel), 32'd3);
    check("fl_data_kept", 32'(hold_data[3*N +: N]), 32'h4);
    check("fl_no_load", 32'(hold_data[4*N +: N]), 32'hC);
    for (int c = 0; c < 3; c++) begin
      step();
      check("fl_stay_idle", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset in the middle of a presented item.
    out_ready = 1'b0;
    in_valid = 8'h02; in_data[1*N +: N] = 4'h7;
    step();
    in_valid = '0;
    step();
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_count", 32'(count), 32'd0);
    check("ar_ready", 32'(in_ready), 32'hFF);
    check("ar_hold", hold_data, 32'd0);
    check("ar_sel", 32'(sel), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    model_ptr = '0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("ar_no_item", 32'(out_valid), 32'd0);
    end
    burst(8'h10, 4'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
